// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the program counter, issues instruction memory
// reads with a bounded wait, latches the returned instruction and its link
// address, and computes the next PC from the control-unit selects.
module fetch_unit #(
    parameter int          MEM_TIMEOUT = 15,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic        zero,
    input  logic [1:0]  pc_source,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_out,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] link_addr,
    output logic        fetch_err
);

    // Counter must hold MEM_TIMEOUT itself, the value reached on abort.
    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic               mem_rd_q, mem_rd_d;
    logic [31:0]        instruction_q, instruction_d;
    logic               instr_valid_q, instr_valid_d;
    logic [31:0]        link_addr_q, link_addr_d;
    logic               fetch_err_q, fetch_err_d;

    logic               pc_load_s;
    logic [31:0]        jump_target_s;

    // Next PC: load is independent of fetch state; jumps stay inside the 256 MB region of the link address.
    always_comb begin
        pc_load_s     = pc_write | (pc_write_cond & zero);
        jump_target_s = {link_addr_q[31:28], instruction_q[25:0], 2'b00};
        pc_d          = pc_q;
        if (pc_load_s) begin
            case (pc_source)
                2'b00:   pc_d = alu_result;
                2'b01:   pc_d = alu_out;
                2'b10:   pc_d = jump_target_s;
                2'b11:   pc_d = pc_q;
                default: pc_d = pc_q;
            endcase
        end else begin
            pc_d = pc_q;
        end
    end

    // Fetch FSM next-state and next-output logic; outputs are registered one step ahead.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_addr_d    = mem_addr_q;
        mem_rd_d      = mem_rd_q;
        instruction_d = instruction_q;
        link_addr_d   = link_addr_q;
        instr_valid_d = 1'b0;
        fetch_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fetch_req) begin
                    state_d    = ST_REQ;
                    mem_addr_d = {pc_q[31:2], 2'b00};
                    wait_cnt_d = {CNT_W{1'b0}};
                    mem_rd_d   = 1'b1;
                end else begin
                    mem_rd_d   = 1'b0;
                end
            end
            ST_REQ: begin
                if (mem_ready) begin
                    state_d       = ST_DONE;
                    instruction_d = mem_rdata;
                    link_addr_d   = mem_addr_q + 32'd4;
                    mem_rd_d      = 1'b0;
                    instr_valid_d = 1'b1;
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    state_d     = ST_IDLE;
                    wait_cnt_d  = wait_cnt_q + CNT_W'(1);
                    mem_rd_d    = 1'b0;
                    fetch_err_d = 1'b1;
                end else begin
                    wait_cnt_d  = wait_cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                mem_rd_d = 1'b0;
            end
            default: begin
                state_d  = ST_IDLE;
                mem_rd_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset overrides every load and transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= {CNT_W{1'b0}};
            pc_q          <= RESET_PC;
            mem_addr_q    <= RESET_PC;
            mem_rd_q      <= 1'b0;
            instruction_q <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
            link_addr_q   <= 32'h0000_0000;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            pc_q          <= pc_d;
            mem_addr_q    <= mem_addr_d;
            mem_rd_q      <= mem_rd_d;
            instruction_q <= instruction_d;
            instr_valid_q <= instr_valid_d;
            link_addr_q   <= link_addr_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_rd      = mem_rd_q;
    assign pc          = pc_q;
    assign instruction = instruction_q;
    assign instr_valid = instr_valid_q;
    assign link_addr   = link_addr_q;
    assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a scoreboard queue holds the expected
// outcome of each fetch and a monitor pops it on instr_valid / fetch_err.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        pc_write;
    logic        pc_write_cond;
    logic        zero;
    logic [1:0]  pc_source;
    logic [31:0] alu_result;
    logic [31:0] alu_out;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] link_addr;
    logic        fetch_err;

    typedef struct {
        logic        err;
        logic [31:0] instr;
        logic [31:0] link;
    } exp_t;

    exp_t sb[$];
    int   check_cnt = 0;
    int   err_cnt   = 0;
    logic prev_valid = 1'b0;
    logic prev_err   = 1'b0;

    fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_req    (fetch_req),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .pc_write_cond(pc_write_cond),
        .zero         (zero),
        .pc_source    (pc_source),
        .alu_result   (alu_result),
        .alu_out      (alu_out),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .pc           (pc),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .link_addr    (link_addr),
        .fetch_err    (fetch_err)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: each completion or abort must match the oldest expectation.
    always @(negedge clk) begin
        if (prev_valid) check("valid_pulse", {31'd0, instr_valid}, 32'd0);
        if (prev_err)   check("err_pulse",   {31'd0, fetch_err},   32'd0);
        if (instr_valid || fetch_err) begin
            if (sb.size() == 0) begin
                check("sb_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_kind", {31'd0, fetch_err}, {31'd0, e.err});
                check("sb_instr", instruction, e.instr);
                if (!e.err) check("sb_link", link_addr, e.link);
            end
        end
        prev_valid = instr_valid;
        prev_err   = fetch_err;
    end

    task automatic push_exp(input logic err, input logic [31:0] instr, input logic [31:0] link);
        exp_t e;
        e.err = err; e.instr = instr; e.link = link;
        sb.push_back(e);
    endtask

    // Starts a fetch (optionally with a simultaneous PC load via alu_result); returns in the first REQ cycle.
    task automatic start_fetch(input logic ld, input logic [31:0] ld_val);
        @(posedge clk); #1;
        fetch_req = 1'b1; pc_write = ld; pc_source = 2'b00; alu_result = ld_val;
        @(posedge clk); #1;
        fetch_req = 1'b0; pc_write = 1'b0;
    endtask

    // Memory response after wait_n idle REQ cycles; returns once the FSM is back in IDLE.
    task automatic respond(input int wait_n, input logic [31:0] data);
        repeat (wait_n) begin @(posedge clk); #1; end
        mem_ready = 1'b1; mem_rdata = data;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic load_pc(input logic [1:0] src, input logic w, input logic wc, input logic z);
        @(posedge clk); #1;
        pc_source = src; pc_write = w; pc_write_cond = wc; zero = z;
        @(posedge clk); #1;
        pc_write = 1'b0; pc_write_cond = 1'b0; zero = 1'b0;
    endtask

    initial begin
        int cnt;
        logic seen;
        reset = 1'b1; fetch_req = 1'b0; mem_rdata = 32'd0; mem_ready = 1'b0;
        pc_write = 1'b0; pc_write_cond = 1'b0; zero = 1'b0; pc_source = 2'b00;
        alu_result = 32'd0; alu_out = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pc", pc, 32'h0000_0000);
        check("rst_addr", mem_addr, 32'h0000_0000);
        check("rst_instr", instruction, 32'h0000_0000);
        check("rst_link", link_addr, 32'h0000_0000);
        check("rst_ctl", {29'd0, mem_rd, instr_valid, fetch_err}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Zero-wait fetch latency: instr_valid two cycles after fetch_req.
        push_exp(1'b0, 32'h0800_000C, 32'h0000_0004);
        @(posedge clk); #1;
        fetch_req = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h0800_000C;
        @(negedge clk) check("lat_c0", {31'd0, instr_valid}, 32'd0);
        @(posedge clk); #1;
        fetch_req = 1'b0;
        @(negedge clk);
        check("lat_c1_rd", {31'd0, mem_rd}, 32'd1);
        check("lat_c1_v", {31'd0, instr_valid}, 32'd0);
        check("lat_c1_addr", mem_addr, 32'h0000_0000);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk) check("lat_c2", {31'd0, instr_valid}, 32'd1);
        @(posedge clk); #1;

        // j 12
        load_pc(2'b10, 1'b1, 1'b0, 1'b0);
        @(negedge clk) check("jump12", pc, 32'h0000_0030);

        // jal 0 from 0x30 with wait states
        push_exp(1'b0, 32'h0C00_0000, 32'h0000_0034);
        start_fetch(1'b0, 32'd0);
        @(negedge clk) check("jal_addr", mem_addr, 32'h0000_0030);
        respond(3, 32'h0C00_0000);
        load_pc(2'b10, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("jal_pc", pc, 32'h0000_0000);
        check("jal_link", link_addr, 32'h0000_0034);

        // Conditional branch
        alu_out = 32'h0000_0040;
        load_pc(2'b01, 1'b0, 1'b1, 1'b0);
        @(negedge clk) check("beq_nz", pc, 32'h0000_0000);
        load_pc(2'b01, 1'b0, 1'b1, 1'b1);
        @(negedge clk) check("beq_z", pc, 32'h0000_0040);
        load_pc(2'b11, 1'b1, 1'b0, 1'b0);
        @(negedge clk) check("src11_hold", pc, 32'h0000_0040);

        // Fetch start with PC load, PC load during REQ, ignored fetch_req during REQ
        push_exp(1'b0, 32'h2000_0003, 32'h0000_0044);
        start_fetch(1'b1, 32'h1234_5677);
        @(negedge clk);
        check("same_cyc_addr", mem_addr, 32'h0000_0040);
        check("same_cyc_pc", pc, 32'h1234_5677);
        @(posedge clk); #1;
        pc_write = 1'b1; pc_source = 2'b00; alu_result = 32'h0000_0100; fetch_req = 1'b1;
        @(posedge clk); #1;
        pc_write = 1'b0; fetch_req = 1'b0;
        @(negedge clk);
        check("req_ld_addr", mem_addr, 32'h0000_0040);
        check("req_ld_pc", pc, 32'h0000_0100);
        respond(0, 32'h2000_0003);
        @(negedge clk) check("no_queue_a", {31'd0, mem_rd}, 32'd0);
        @(negedge clk) check("no_queue_b", {31'd0, mem_rd}, 32'd0);

        // Unaligned PC: mem_addr low bits forced to zero, pc keeps them
        alu_result = 32'h0000_0207;
        load_pc(2'b00, 1'b1, 1'b0, 1'b0);
        @(negedge clk) check("pc_full", pc, 32'h0000_0207);
        push_exp(1'b0, 32'h1111_2222, 32'h0000_0208);
        start_fetch(1'b0, 32'd0);
        @(negedge clk) check("addr_align", mem_addr, 32'h0000_0204);
        respond(0, 32'h1111_2222);

        // Timeout: 15 REQ cycles with mem_ready low, then fetch_err
        push_exp(1'b1, 32'h1111_2222, 32'h0000_0000);
        start_fetch(1'b0, 32'd0);
        cnt = 0; seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fetch_err) begin
                seen = 1'b1;
                break;
            end
            if (mem_rd) cnt++;
        end
        check("to_seen", {31'd0, seen}, 32'd1);
        check("to_cycles", cnt, 32'd15);
        check("to_rd_off", {31'd0, mem_rd}, 32'd0);
        @(negedge clk) check("to_instr", instruction, 32'h1111_2222);

        // Jump target wraps inside the top 256 MB region
        alu_result = 32'hF000_0000;
        load_pc(2'b00, 1'b1, 1'b0, 1'b0);
        push_exp(1'b0, 32'h0BFF_FFFF, 32'hF000_0004);
        start_fetch(1'b0, 32'd0);
        respond(2, 32'h0BFF_FFFF);
        load_pc(2'b10, 1'b1, 1'b0, 1'b0);
        @(negedge clk) check("jump_wrap", pc, 32'hFFFF_FFFC);

        // Reset on 3rd REQ cycle beats a PC load; late mem_ready ignored
        start_fetch(1'b0, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; pc_write = 1'b1; pc_source = 2'b00; alu_result = 32'hDEAD_BEE0;
        @(posedge clk); #1;
        reset = 1'b0; pc_write = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid_rst_instr", instruction, 32'h0000_0000);
        check("mid_rst_pc", pc, 32'h0000_0000);
        check("mid_rst_link", link_addr, 32'h0000_0000);
        check("mid_rst_rd", {31'd0, mem_rd}, 32'd0);

        check("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end

endmodule
